avalon_mm_master_arb: RTL and testbench

Parametrised Avalon-MM bus master front end for the multi-cycle MIPS core and its successors: arbitrates N requesting channels (e.g. instruction fetch, data load/store, debug) onto a single Avalon-MM master port. Each channel gets a round-robin grant. The block holds every bus transfer stable across `waitrequest` stalls and optionally byte-reverses data lanes between core (big-endian) and bus (little-endian) order. It replaces ad-hoc read/write/waitrequest handling in the memory unit, and allows back-to-back transfers.

---
 rtl/avalon_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/avalon_mm_master_arb.sv | 141 ++++++++++++++
 tb/tb_avalon_mm_master_arb.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pkg.sv
// Shared types and helpers for the Avalon-MM master front end.
package avalon_pkg;

    typedef enum logic {IDLE, ISSUE} avm_state_t;

    // Widest data bus swap_bytes can handle; callers pad up to it and slice back down.
    localparam int SWAP_MAX_W = 1024;

    function automatic logic [SWAP_MAX_W-1:0] swap_bytes(input logic [SWAP_MAX_W-1:0] data,
                                                         input int width);
        logic [SWAP_MAX_W-1:0] result;
        result = '0;
        for (int k = 0; k < SWAP_MAX_W / 8; k++) begin
            if (k < width / 8) begin
                result[k*8 +: 8] = data[(width/8 - 1 - k)*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 and wraps,
// so the previous winner has the lowest priority.
module rr_arbiter #(
    parameter int N_CHAN = 2,
    parameter int IDX_W  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic [N_CHAN-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    input  logic              en,
    output logic [N_CHAN-1:0] grant
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        if (en) begin
            for (int off = 1; off <= N_CHAN; off++) begin
                idx = IDX_W'((int'(last_grant) + off) % N_CHAN);
                if (!found && req[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/avalon_mm_master_arb.sv
// Round-robin N-channel front end onto one Avalon-MM master port with optional byte swap.
// Optional stall timeout enabled by defining AVALON_TIMEOUT_EN.
module avalon_mm_master_arb import avalon_pkg::*; #(
    parameter int N_CHAN  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SWAP    = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_CHAN-1:0]            req_valid,
    input  logic [N_CHAN-1:0]            req_write,
    input  logic [N_CHAN*ADDR_W-1:0]     req_addr,
    input  logic [N_CHAN*DATA_W-1:0]     req_wdata,
    input  logic [N_CHAN*(DATA_W/8)-1:0] req_be,
    output logic [N_CHAN-1:0]            req_ready,
    output logic [N_CHAN-1:0]            rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [ADDR_W-1:0]            address,
    output logic                         write,
    output logic                         read,
    output logic [DATA_W-1:0]            writedata,
    output logic [DATA_W/8-1:0]          byteenable,
    input  logic                         waitrequest,
    input  logic [DATA_W-1:0]            readdata,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int IDX_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int BE_W  = DATA_W / 8;

    avm_state_t           state;
    logic [IDX_W-1:0]     last_grant;
    logic [IDX_W-1:0]     grant_idx;
    logic [N_CHAN-1:0]    grant;
    logic                 complete;
    logic                 abort;
    logic                 grant_en;
    logic [DATA_W-1:0]    sel_wdata;
    logic [DATA_W-1:0]    wdata_bus;
    logic [DATA_W-1:0]    rdata_core;
    logic [SWAP_MAX_W-1:0] wdata_pad;
    logic [SWAP_MAX_W-1:0] rdata_pad;

    // A new grant can ride on the completion edge, giving one transfer per cycle.
    assign complete = (state == ISSUE) && !waitrequest;
    assign grant_en = (state == IDLE) || complete;
    assign req_ready = grant;
    assign busy      = (state == ISSUE);

    rr_arbiter #(.N_CHAN(N_CHAN), .IDX_W(IDX_W)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .en         (grant_en),
        .grant      (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (grant[i]) grant_idx = IDX_W'(i);
        end
        sel_wdata  = req_wdata[grant_idx*DATA_W +: DATA_W];
        wdata_pad  = swap_bytes(SWAP_MAX_W'(sel_wdata), DATA_W);
        rdata_pad  = swap_bytes(SWAP_MAX_W'(readdata), DATA_W);
        wdata_bus  = (SWAP != 0) ? wdata_pad[DATA_W-1:0] : sel_wdata;
        rdata_core = (SWAP != 0) ? rdata_pad[DATA_W-1:0] : readdata;
    end

`ifdef AVALON_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] stall_cnt;
    logic             rsp_err_r;
    logic             timeout_err_r;

    // Abort on the stall edge that would bring the count up to TIMEOUT.
    assign abort       = (state == ISSUE) && waitrequest && (stall_cnt == CNT_W'(TIMEOUT - 1));
    assign rsp_err     = rsp_err_r;
    assign timeout_err = timeout_err_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt     <= '0;
            rsp_err_r     <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            rsp_err_r <= abort;
            if (abort) timeout_err_r <= 1'b1;
            if (|grant) begin
                stall_cnt <= '0;
            end else if ((state == ISSUE) && waitrequest) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign abort          = 1'b0;
    assign rsp_err        = 1'b0;
    assign timeout_err    = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    // last_grant doubles as the channel of the transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= IDX_W'(N_CHAN - 1);
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            rsp_rdata  <= '0;
            rsp_valid  <= '0;
        end else begin
            rsp_valid <= '0;
            if (complete || abort) rsp_valid <= N_CHAN'(1) << last_grant;
            if (complete && read) rsp_rdata <= rdata_core;
            if (|grant) begin
                state      <= ISSUE;
                last_grant <= grant_idx;
                read       <= !req_write[grant_idx];
                write      <= req_write[grant_idx];
                address    <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                writedata  <= wdata_bus;
                byteenable <= req_be[grant_idx*BE_W +: BE_W];
            end else if (complete || abort) begin
                state <= IDLE;
                read  <= 1'b0;
                write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_avalon_mm_master_arb.sv
// Bench for avalon_mm_master_arb: directed vector table, reset/round-robin/timeout
// sequences, and a randomized run against a transaction-level reference model.
module tb_avalon_mm_master_arb;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: 2 channels, byte swap on.
    logic [1:0]  a_req_valid, a_req_write, a_req_ready, a_rsp_valid;
    logic [63:0] a_req_addr, a_req_wdata;
    logic [7:0]  a_req_be;
    logic [31:0] a_rsp_rdata, a_address, a_writedata, a_readdata;
    logic        a_rsp_err, a_write, a_read, a_waitrequest, a_busy, a_timeout_err;
    logic [3:0]  a_byteenable;

    // Instance B: 3 channels, pass-through.
    logic [2:0]  b_req_valid, b_req_write, b_req_ready, b_rsp_valid;
    logic [95:0] b_req_addr, b_req_wdata;
    logic [11:0] b_req_be;
    logic [31:0] b_rsp_rdata, b_address, b_writedata, b_readdata;
    logic        b_rsp_err, b_write, b_read, b_waitrequest, b_busy, b_timeout_err;
    logic [3:0]  b_byteenable;

    avalon_mm_master_arb #(.N_CHAN(2), .ADDR_W(32), .DATA_W(32), .SWAP(1), .TIMEOUT(4)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_write(a_req_write), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .req_be(a_req_be), .req_ready(a_req_ready),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .address(a_address), .write(a_write), .read(a_read), .writedata(a_writedata),
        .byteenable(a_byteenable), .waitrequest(a_waitrequest), .readdata(a_readdata),
        .busy(a_busy), .timeout_err(a_timeout_err)
    );

    avalon_mm_master_arb #(.N_CHAN(3), .ADDR_W(32), .DATA_W(32), .SWAP(0), .TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_write(b_req_write), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_be(b_req_be), .req_ready(b_req_ready),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .address(b_address), .write(b_write), .read(b_read), .writedata(b_writedata),
        .byteenable(b_byteenable), .waitrequest(b_waitrequest), .readdata(b_readdata),
        .busy(b_busy), .timeout_err(b_timeout_err)
    );

    typedef struct {
        logic [1:0]  rv;
        logic [1:0]  rw;
        logic        wr;
        logic [31:0] rd;
        logic [1:0]  ready;
        logic        rd_o;
        logic        wr_o;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [1:0]  rsp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [16];

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {<<8{x}};
    endfunction

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s @%0d: actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        a_req_valid   = v.rv;
        a_req_write   = v.rw;
        a_waitrequest = v.wr;
        a_readdata    = v.rd;
    endtask

    task automatic checkOutput(input vec_t v, input int i);
        check("vec.ready",    i, 32'(a_req_ready),  32'(v.ready));
        check("vec.read",     i, 32'(a_read),       32'(v.rd_o));
        check("vec.write",    i, 32'(a_write),      32'(v.wr_o));
        check("vec.address",  i, a_address,         v.addr);
        check("vec.wdata",    i, a_writedata,       v.wdata);
        check("vec.be",       i, 32'(a_byteenable), 32'(v.be));
        check("vec.rsp",      i, 32'(a_rsp_valid),  32'(v.rsp));
        check("vec.rdata",    i, a_rsp_rdata,       v.rdata);
        check("vec.rsp_err",  i, 32'(a_rsp_err),    32'h0);
        check("vec.tmo_err",  i, 32'(a_timeout_err), 32'h0);
    endtask

    task automatic run_vector(input int i);
        applyStimulus(vecs[i]);
        @(negedge clk);
        checkOutput(vecs[i], i);
        next_cycle();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

    // Reference model state for the random run
    logic        p_valid [2];
    logic        p_write [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic [3:0]  p_be    [2];
    logic        m_busy, m_write;
    int          m_chan, m_last;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;
    logic [1:0]  m_rsp;

    task automatic random_run(input int cycles);
        int stall_run = 0;
        m_busy = 0; m_write = 0; m_chan = 0; m_last = 1;
        m_addr = 0; m_wdata = 0; m_rdata = 0; m_be = 0; m_rsp = 0;
        for (int i = 0; i < 2; i++) p_valid[i] = 0;
        for (int c = 0; c < cycles; c++) begin
            int g;
            logic wr;
            logic [31:0] rd;
            logic completing;
            for (int i = 0; i < 2; i++) begin
                if (!p_valid[i] && $urandom_range(0, 2) != 0) begin
                    p_valid[i] = 1'b1;
                    p_write[i] = 1'($urandom_range(0, 1));
                    p_addr[i]  = $urandom;
                    p_wdata[i] = $urandom;
                    p_be[i]    = 4'($urandom_range(0, 15));
                end
                a_req_valid[i]          = p_valid[i];
                a_req_write[i]          = p_write[i];
                a_req_addr[i*32 +: 32]  = p_addr[i];
                a_req_wdata[i*32 +: 32] = p_wdata[i];
                a_req_be[i*4 +: 4]      = p_be[i];
            end
            wr = (stall_run >= 3) ? 1'b0 : 1'($urandom_range(0, 1));
            stall_run = wr ? stall_run + 1 : 0;
            rd = $urandom;
            a_waitrequest = wr;
            a_readdata    = rd;
            g = -1;
            if (!m_busy || !wr) begin
                for (int k = 1; k <= 2; k++) begin
                    int ch = (m_last + k) % 2;
                    if (g < 0 && p_valid[ch]) g = ch;
                end
            end
            @(negedge clk);
            check("rand.ready", c, 32'(a_req_ready), (g >= 0) ? (32'h1 << g) : 32'h0);
            check("rand.read",  c, 32'(a_read),      32'(m_busy && !m_write));
            check("rand.write", c, 32'(a_write),     32'(m_busy && m_write));
            check("rand.addr",  c, a_address,        m_addr);
            check("rand.wdata", c, a_writedata,      m_wdata);
            check("rand.be",    c, 32'(a_byteenable), 32'(m_be));
            check("rand.rsp",   c, 32'(a_rsp_valid), 32'(m_rsp));
            check("rand.rdata", c, a_rsp_rdata,      m_rdata);
            check("rand.busy",  c, 32'(a_busy),      32'(m_busy));
            completing = m_busy && !wr;
            m_rsp = completing ? 2'(1 << m_chan) : 2'b00;
            if (completing && !m_write) m_rdata = bswap(rd);
            if (g >= 0) begin
                m_busy  = 1'b1;
                m_chan  = g;
                m_last  = g;
                m_write = p_write[g];
                m_addr  = p_addr[g];
                m_wdata = bswap(p_wdata[g]);
                m_be    = p_be[g];
                p_valid[g] = 1'b0;
            end else if (completing) begin
                m_busy = 1'b0;
            end
            next_cycle();
        end
        a_req_valid = '0;
    endtask

    initial begin
        vecs[0]  = '{2'b01, 2'b00, 1'b0, 32'h0,        2'b01, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 2'b00, 32'h0};
        vecs[1]  = '{2'b00, 2'b00, 1'b0, 32'h11223344, 2'b00, 1'b1, 1'b0, 32'h1000, 32'h04030201, 4'h3, 2'b00, 32'h0};
        vecs[2]  = '{2'b00, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 32'h1000, 32'h04030201, 4'h3, 2'b01, 32'h44332211};
        vecs[3]  = '{2'b00, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 32'h1000, 32'h04030201, 4'h3, 2'b00, 32'h44332211};
        vecs[4]  = '{2'b10, 2'b10, 1'b1, 32'h0,        2'b10, 1'b0, 1'b0, 32'h1000, 32'h04030201, 4'h3, 2'b00, 32'h44332211};
        vecs[5]  = '{2'b00, 2'b00, 1'b1, 32'h0,        2'b00, 1'b0, 1'b1, 32'h2000, 32'hDDCCBBAA, 4'hF, 2'b00, 32'h44332211};
        vecs[6]  = vecs[5];
        vecs[7]  = vecs[5];
        vecs[8]  = '{2'b00, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b1, 32'h2000, 32'hDDCCBBAA, 4'hF, 2'b00, 32'h44332211};
        vecs[9]  = '{2'b00, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 32'h2000, 32'hDDCCBBAA, 4'hF, 2'b10, 32'h44332211};
        vecs[10] = '{2'b11, 2'b10, 1'b0, 32'hA0B0C0D0, 2'b01, 1'b0, 1'b0, 32'h2000, 32'hDDCCBBAA, 4'hF, 2'b00, 32'h44332211};
        vecs[11] = '{2'b11, 2'b10, 1'b0, 32'h55667788, 2'b10, 1'b1, 1'b0, 32'h1000, 32'h04030201, 4'h3, 2'b00, 32'h44332211};
        vecs[12] = '{2'b11, 2'b10, 1'b0, 32'h99AABBCC, 2'b01, 1'b0, 1'b1, 32'h2000, 32'hDDCCBBAA, 4'hF, 2'b01, 32'h88776655};
        vecs[13] = '{2'b00, 2'b10, 1'b0, 32'h12345678, 2'b00, 1'b1, 1'b0, 32'h1000, 32'h04030201, 4'h3, 2'b10, 32'h88776655};
        vecs[14] = '{2'b00, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 32'h1000, 32'h04030201, 4'h3, 2'b01, 32'h78563412};
        vecs[15] = '{2'b00, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 32'h1000, 32'h04030201, 4'h3, 2'b00, 32'h78563412};

        a_req_valid = '0; a_req_write = '0; a_waitrequest = 1'b0; a_readdata = '0;
        a_req_addr  = {32'h2000, 32'h1000};
        a_req_wdata = {32'hAABBCCDD, 32'h01020304};
        a_req_be    = {4'hF, 4'h3};
        b_req_valid = '0; b_req_write = '0; b_waitrequest = 1'b0; b_readdata = 32'hCAFEF00D;
        b_req_addr  = {32'h300, 32'h200, 32'h100};
        b_req_wdata = '0;
        b_req_be    = 12'hFFF;

        // Reset values while reset is held
        @(negedge clk);
        check("reset.read",  0, 32'(a_read),       32'h0);
        check("reset.write", 0, 32'(a_write),      32'h0);
        check("reset.addr",  0, a_address,         32'h0);
        check("reset.wdata", 0, a_writedata,       32'h0);
        check("reset.be",    0, 32'(a_byteenable), 32'h0);
        check("reset.rsp",   0, 32'(a_rsp_valid),  32'h0);
        check("reset.rdata", 0, a_rsp_rdata,       32'h0);
        check("reset.busy",  0, 32'(a_busy),       32'h0);
        check("reset.err",   0, 32'(a_rsp_err | a_timeout_err), 32'h0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        for (int i = 0; i < 16; i++) run_vector(i);

        // Reset during a stalled read: read falls at once, no response follows
        a_req_valid = 2'b01; a_req_write = 2'b00; a_waitrequest = 1'b1;
        @(negedge clk);
        check("abort.ready", 0, 32'(a_req_ready), 32'h1);
        next_cycle();
        a_req_valid = 2'b00;
        @(negedge clk);
        check("abort.read_before", 0, 32'(a_read), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("abort.read_async", 0, 32'(a_read), 32'h0);
        check("abort.busy",       0, 32'(a_busy), 32'h0);
        next_cycle();
        reset = 1'b0;
        a_waitrequest = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort.no_rsp", i, 32'(a_rsp_valid), 32'h0);
            next_cycle();
        end
        for (int i = 0; i < 4; i++) run_vector(i);

        // Three channels: after a grant to 1, channel 2 goes before channel 1
        b_req_valid = 3'b010;
        @(negedge clk);
        check("rr3.ready_a", 0, 32'(b_req_ready), 32'h2);
        next_cycle();
        b_req_valid = 3'b110;
        @(negedge clk);
        check("rr3.ready_b", 1, 32'(b_req_ready), 32'h4);
        check("rr3.addr_b",  1, b_address,        32'h200);
        check("rr3.read_b",  1, 32'(b_read),      32'h1);
        next_cycle();
        b_req_valid = 3'b010;
        @(negedge clk);
        check("rr3.ready_c", 2, 32'(b_req_ready), 32'h2);
        check("rr3.addr_c",  2, b_address,        32'h300);
        check("rr3.rsp_c",   2, 32'(b_rsp_valid), 32'h2);
        check("rr3.rdata_c", 2, b_rsp_rdata,      32'hCAFEF00D);
        next_cycle();
        b_req_valid = 3'b000;
        @(negedge clk);
        check("rr3.addr_d",  3, b_address,        32'h200);
        check("rr3.rsp_d",   3, 32'(b_rsp_valid), 32'h4);
        next_cycle();

        pulse_reset();
        random_run(400);
        @(negedge clk);
        check("rand.tmo_err", 0, 32'(a_timeout_err), 32'h0);
        next_cycle();

`ifdef AVALON_TIMEOUT_EN
        // Stuck waitrequest: read held 4 cycles, then an error response
        pulse_reset();
        a_req_valid = 2'b01; a_req_write = 2'b00; a_waitrequest = 1'b1; a_readdata = 32'hDEADBEEF;
        @(negedge clk);
        check("tmo.ready", 0, 32'(a_req_ready), 32'h1);
        next_cycle();
        a_req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("tmo.read_held", i, 32'(a_read), 32'h1);
            next_cycle();
        end
        @(negedge clk);
        check("tmo.read_drop", 0, 32'(a_read),        32'h0);
        check("tmo.rsp",       0, 32'(a_rsp_valid),   32'h1);
        check("tmo.rsp_err",   0, 32'(a_rsp_err),     32'h1);
        check("tmo.sticky",    0, 32'(a_timeout_err), 32'h1);
        check("tmo.rdata",     0, a_rsp_rdata,        32'h0);
        next_cycle();
        @(negedge clk);
        check("tmo.err_pulse", 1, 32'(a_rsp_err),     32'h0);
        check("tmo.sticky2",   1, 32'(a_timeout_err), 32'h1);
        next_cycle();
        pulse_reset();
        @(negedge clk);
        check("tmo.cleared",   2, 32'(a_timeout_err), 32'h0);
        next_cycle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
